// File: rtl/p_fetch_if.sv
// p_fetch_if: the handshake and bus signals of the fetch stage.
//   imem_*     : single-outstanding instruction memory read port
//   insn_*     : valid/ready instruction hand-off to decode
//   redirect*  : restart strobe and target from execute
//   busy       : fetch stage is waiting on memory or holding an instruction
// master = fetch stage, slave = its environment (memory, decode, execute).
interface p_fetch_if #(
  parameter int ADDR_W = 12
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic              insn_valid;
  logic              insn_ready;
  logic [31:0]       insn_data;
  logic [4:0]        insn_opcode;
  logic [ADDR_W-1:0] insn_pc;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              busy;

  modport master (
    output imem_req, imem_addr, insn_valid, insn_data, insn_opcode, insn_pc, busy,
    input  imem_ack, imem_rdata, insn_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, insn_valid, insn_data, insn_opcode, insn_pc, busy,
    output imem_ack, imem_rdata, insn_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/p_fetch.sv
// p_fetch: instruction fetch/issue stage.
// Holds the PC, issues one read at a time to instruction memory, presents the
// returned word (plus opcode field and PC) to decode over valid/ready, and
// restarts on redirect while dropping any wrong-path read still in flight.
// Ports:
//   clock  : system clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : p_fetch_if.master (imem, insn, redirect, busy)
// All outputs are registered; insn_opcode is a field of the held word.
module p_fetch #(
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic      clock,
  input  logic      resetn,
  p_fetch_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_HOLD} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              disc_q, disc_d;   // in-flight read is wrong-path
  logic              cap;              // capture returned word this cycle
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic              valid_q;
  logic [31:0]       data_q;
  logic [ADDR_W-1:0] ipc_q;
  logic              busy_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    disc_d  = disc_q;
    cap     = 1'b0;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        // The request still goes out; its data is marked for dropping.
        state_d = S_WAIT;
        if (bus.redirect) begin
          disc_d = 1'b1;
          pc_d   = bus.redirect_pc;
        end
      end
      S_WAIT: begin
        if (bus.imem_ack) begin
          state_d = S_FETCH;
          disc_d  = 1'b0;
          if (bus.redirect) begin
            pc_d = bus.redirect_pc;
          end else if (!disc_q) begin
            cap     = 1'b1;
            pc_d    = pc_q + 1'b1;   // wraps modulo 2^ADDR_W
            state_d = S_HOLD;
          end
        end else if (bus.redirect) begin
          disc_d = 1'b1;
          pc_d   = bus.redirect_pc;
        end
      end
      S_HOLD: begin
        // Redirect withdraws the held word even if decode is ready.
        if (bus.redirect) begin
          pc_d    = bus.redirect_pc;
          state_d = S_FETCH;
        end else if (bus.insn_ready) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are derived from the next state so they line up with it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      disc_q  <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ipc_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      disc_q  <= disc_d;
      req_q   <= (state_d == S_FETCH);
      if (state_d == S_FETCH) addr_q <= pc_d;
      valid_q <= (state_d == S_HOLD);
      busy_q  <= (state_d == S_WAIT) || (state_d == S_HOLD);
      if (cap) begin
        data_q <= bus.imem_rdata;
        ipc_q  <= pc_q;
      end
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.insn_valid  = valid_q;
  assign bus.insn_data   = data_q;
  assign bus.insn_opcode = data_q[31:27];
  assign bus.insn_pc     = ipc_q;
  assign bus.busy        = busy_q;

endmodule
